// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, IF/ID pipeline
// register and saturating stall/flush event counters.
module fetch_stage #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  NOP      = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCStall,
  input  logic              IFIDStall,
  input  logic              Flush,
  input  logic [DATA_W-1:0] BranchTarget,
  input  logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] PC_IFID,
  output logic [DATA_W-1:0] PCPlus4_IFID,
  output logic [DATA_W-1:0] Instr_IFID,
  output logic              Valid_IFID,
  output logic [31:0]       StallCount,
  output logic [31:0]       FlushCount
);

  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] redirect_pc;
  logic              stall_event;

  // Targets are forced word-aligned; misaligned redirects are silently truncated.
  assign pc_plus4    = PC + DATA_W'(4);
  assign redirect_pc = {BranchTarget[DATA_W-1:2], 2'b00};
  assign stall_event = PCStall && !Flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
    end else if (Flush) begin
      PC <= redirect_pc;
    end else if (!PCStall) begin
      PC <= pc_plus4;
    end
  end

  // A flush squashes the younger instruction even when decode asks to hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_IFID      <= '0;
      PCPlus4_IFID <= '0;
      Instr_IFID   <= NOP;
      Valid_IFID   <= 1'b0;
    end else if (Flush) begin
      PC_IFID      <= '0;
      PCPlus4_IFID <= '0;
      Instr_IFID   <= NOP;
      Valid_IFID   <= 1'b0;
    end else if (!IFIDStall) begin
      PC_IFID      <= PC;
      PCPlus4_IFID <= pc_plus4;
      Instr_IFID   <= Instr;
      Valid_IFID   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall_event && (StallCount != 32'hFFFF_FFFF)) begin
        StallCount <= StallCount + 32'd1;
      end
      if (Flush && (FlushCount != 32'hFFFF_FFFF)) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: normal fetch, stalls, flushes,
// PC wrap, counter saturation and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        PCStall;
  logic        IFIDStall;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PC_IFID;
  logic [31:0] PCPlus4_IFID;
  logic [31:0] Instr_IFID;
  logic        Valid_IFID;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PCStall      (PCStall),
    .IFIDStall    (IFIDStall),
    .Flush        (Flush),
    .BranchTarget (BranchTarget),
    .Instr        (Instr),
    .PC           (PC),
    .PC_IFID      (PC_IFID),
    .PCPlus4_IFID (PCPlus4_IFID),
    .Instr_IFID   (Instr_IFID),
    .Valid_IFID   (Valid_IFID),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc_stall;
    logic        ifid_stall;
    logic        flush;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc_ifid;
    logic [31:0] exp_pc4_ifid;
    logic [31:0] exp_instr_ifid;
    logic        exp_valid;
    logic [31:0] exp_stall_cnt;
    logic [31:0] exp_flush_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc_ifid,
                              input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_valid,
                              input logic [31:0] e_sc, input logic [31:0] e_fc);
    check_value({tag, " PC"}, PC, e_pc);
    check_value({tag, " PC_IFID"}, PC_IFID, e_pc_ifid);
    check_value({tag, " PCPlus4_IFID"}, PCPlus4_IFID, e_pc4);
    check_value({tag, " Instr_IFID"}, Instr_IFID, e_instr);
    check_value({tag, " Valid_IFID"}, {31'd0, Valid_IFID}, {31'd0, e_valid});
    check_value({tag, " StallCount"}, StallCount, e_sc);
    check_value({tag, " FlushCount"}, FlushCount, e_fc);
  endtask

  task automatic apply_stimulus(input logic ps, input logic is, input logic fl,
                                input logic [31:0] tgt, input logic [31:0] ins);
    PCStall      = ps;
    IFIDStall    = is;
    Flush        = fl;
    BranchTarget = tgt;
    Instr        = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {pcs, ifs, flush, target, instr, pc, pc_ifid, pc4_ifid, instr_ifid, valid, stall, flush}
    vecs[0]  = '{0, 0, 0, 32'h0,         32'h0010_0093, 32'h4,         32'h0,         32'h4,   32'h0010_0093, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,         32'hAAAA_0001, 32'h8,         32'h4,         32'h8,   32'hAAAA_0001, 1, 0, 0};
    vecs[2]  = '{1, 1, 0, 32'h0,         32'hBBBB_0002, 32'h8,         32'h4,         32'h8,   32'hAAAA_0001, 1, 1, 0};
    vecs[3]  = '{1, 1, 0, 32'h0,         32'hBBBB_0002, 32'h8,         32'h4,         32'h8,   32'hAAAA_0001, 1, 2, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,         32'hBBBB_0002, 32'hC,         32'h8,         32'hC,   32'hBBBB_0002, 1, 2, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,         32'hCCCC_0003, 32'h10,        32'hC,         32'h10,  32'hCCCC_0003, 1, 2, 0};
    vecs[6]  = '{0, 0, 1, 32'h0000_0103, 32'hDDDD_0004, 32'h100,       32'h0,         32'h0,   32'h0000_0013, 0, 2, 1};
    vecs[7]  = '{0, 0, 0, 32'h0,         32'hEEEE_0005, 32'h104,       32'h100,       32'h104, 32'hEEEE_0005, 1, 2, 1};
    vecs[8]  = '{1, 0, 0, 32'h0,         32'hFFFF_0006, 32'h104,       32'h104,       32'h108, 32'hFFFF_0006, 1, 3, 1};
    vecs[9]  = '{0, 1, 0, 32'h0,         32'h1111_0007, 32'h108,       32'h104,       32'h108, 32'hFFFF_0006, 1, 3, 1};
    vecs[10] = '{1, 1, 1, 32'h0000_0040, 32'h2222_0008, 32'h40,        32'h0,         32'h0,   32'h0000_0013, 0, 3, 2};
    vecs[11] = '{0, 0, 1, 32'hFFFF_FFFF, 32'h3333_0009, 32'hFFFF_FFFC, 32'h0,         32'h0,   32'h0000_0013, 0, 3, 3};
    vecs[12] = '{0, 0, 0, 32'h0,         32'h4444_000A, 32'h0,         32'hFFFF_FFFC, 32'h0,   32'h4444_000A, 1, 3, 3};
    vecs[13] = '{0, 0, 0, 32'h0,         32'h5555_000B, 32'h4,         32'h0,         32'h4,   32'h5555_000B, 1, 3, 3};

    reset        = 1'b1;
    PCStall      = 1'b0;
    IFIDStall    = 1'b0;
    Flush        = 1'b0;
    BranchTarget = '0;
    Instr        = 32'h0010_0093;
    #1;
    check_output("reset", 32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check_output("reset held", 32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].pc_stall, vecs[i].ifid_stall, vecs[i].flush, vecs[i].target, vecs[i].instr);
      check_output($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pc_ifid, vecs[i].exp_pc4_ifid,
                   vecs[i].exp_instr_ifid, vecs[i].exp_valid, vecs[i].exp_stall_cnt, vecs[i].exp_flush_cnt);
    end

    // Stall counter saturation: start one below the ceiling.
    @(negedge clk);
    force dut.StallCount = 32'hFFFF_FFFE;
    #1;
    release dut.StallCount;
    #1;
    check_value("preload StallCount", StallCount, 32'hFFFF_FFFE);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h6666_000C);
    check_value("sat step1 StallCount", StallCount, 32'hFFFF_FFFF);
    check_value("sat step1 PC", PC, 32'h4);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h6666_000C);
    check_value("sat step2 StallCount", StallCount, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h6666_000C);
    check_value("sat step3 StallCount", StallCount, 32'hFFFF_FFFF);
    check_value("sat FlushCount", FlushCount, 32'h3);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    check_output("async reset", 32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h7777_000D);
    check_output("post reset fetch", 32'h4, 32'h0, 32'h4, 32'h7777_000D, 1'b1, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline: holds the program counter, computes the next fetch address and owns the IF/ID pipeline register. It sits directly upstream of decode and of the load-use hazard detector. It consumes that detector's hold requests and the EX-stage branch/jump redirect. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- DATA_W, 32, address/instruction width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP, 32'h0000_0013, instruction injected on flush/reset (addi x0,x0,0)

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- PCStall  in  1  1 = hold PC this cycle (load-use hazard)
- IFIDStall  in  1  1 = hold IF/ID register this cycle
- Flush  in  1  1 = taken branch/jump resolved in EX; redirect and squash
- BranchTarget  in  DATA_W  redirect address, valid when Flush=1
- Instr  in  DATA_W  instruction memory read data for address PC (combinational)
- PC  out  DATA_W  current fetch address to instruction memory
- PC_IFID  out  DATA_W  PC of instruction held in IF/ID
- PCPlus4_IFID  out  DATA_W  PC_IFID+4, for JAL/JALR link
- Instr_IFID  out  DATA_W  instruction held in IF/ID
- Valid_IFID  out  1  1 = IF/ID holds a real fetched instruction
- StallCount  out  32  cycles with PCStall=1 and Flush=0, saturating
- FlushCount  out  32  cycles with Flush=1, saturating

## Operation
- Reset values: PC=RESET_PC, PC_IFID=0, PCPlus4_IFID=0, Instr_IFID=NOP, Valid_IFID=0, StallCount=0, FlushCount=0.
- Next-PC priority, evaluated every cycle:
  - Flush=1: PC <= {BranchTarget[DATA_W-1:2], 2'b00}. Flush overrides PCStall.
  - Otherwise, PCStall=1: PC holds.
  - Otherwise: PC <= PC+4, modulo 2^DATA_W. 32'hFFFF_FFFC wraps to 0.
- IF/ID priority:
  - Flush=1: Instr_IFID<=NOP, Valid_IFID<=0, PC_IFID<=0, PCPlus4_IFID<=0. Overrides IFIDStall.
  - Otherwise, IFIDStall=1: all IF/ID fields hold.
  - Otherwise: PC_IFID<=PC, PCPlus4_IFID<=PC+4 (same wrap), Instr_IFID<=Instr, Valid_IFID<=1.
- Stall inputs are independent:
  - PCStall=1 with IFIDStall=0 re-captures the same PC into IF/ID (duplicate fetch). This is legal and defined.
  - PCStall=0 with IFIDStall=1 advances PC and drops the instruction at the old PC. Behaviour is defined as above, but the hazard logic never issues this combination.
- Counters:
  - StallCount increments when PCStall=1 and Flush=0.
  - FlushCount increments when Flush=1.
  - Both stop at 32'hFFFF_FFFF and do not wrap.
- BranchTarget bits [1:0] are ignored; this block raises no misalignment trap.

## Timing
- Fetch latency is 1 cycle: Instr sampled at PC in cycle n appears on Instr_IFID after edge n+1.
- Redirect: Flush high in cycle n gives PC=target after edge n+1, with one NOP bubble in IF/ID. The first target instruction reaches IF/ID after edge n+2.
- Stall: PCStall=IFIDStall=1 for k cycles freezes PC and IF/ID for exactly k edges. Fetch resumes on the first edge with both low.
- Reset asserted mid-operation forces all reset values asynchronously, without waiting for clk. The first fetch after deassertion uses RESET_PC.
- All outputs are registered except none combinational: PC is the register output itself.

## Test plan
- Reset release, Instr=32'h0010_0093, no stalls/flush for 3 cycles -> PC 0→4→8→C; IF/ID shows PC_IFID 0,4,8, Valid_IFID=1 from the first edge.
- PC=8, PCStall=IFIDStall=1 for 2 cycles -> PC stays 8, IF/ID frozen, StallCount=2; next cycle PC=C.
- PC=10, Flush=1, BranchTarget=32'h0000_0103 -> next PC=100, Instr_IFID=32'h13, Valid_IFID=0, FlushCount=1.
- Flush=1 and PCStall=IFIDStall=1 in the same cycle, BranchTarget=40 -> PC=40, IF/ID squashed, StallCount unchanged.
- PC=32'hFFFF_FFFC, no stall -> PC wraps to 0, PCPlus4_IFID=0.
- Preload StallCount to 32'hFFFF_FFFF, PCStall=1 -> StallCount stays FFFF_FFFF. Then assert reset between clock edges -> all outputs take reset values immediately.
